deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_if.sv | 35 +++
 rtl/deserializer.sv | 110 +++++++++++
 tb/tb_deserializer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/deserializer_if.sv
// Serial-in / parallel-out bus between a bit source and the deserializer.
interface deserializer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MOD_W  = $clog2(DATA_W)
);
    logic              ser_data_i;
    logic              ser_data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;
    logic              drop_o;
    logic              busy_o;

    // Bit source side
    modport master (
        output ser_data_i,
        output ser_data_val_i,
        input  deser_data_o,
        input  deser_data_mod_o,
        input  deser_data_val_o,
        input  drop_o,
        input  busy_o
    );

    // Deserializer side
    modport slave (
        input  ser_data_i,
        input  ser_data_val_i,
        output deser_data_o,
        output deser_data_mod_o,
        output deser_data_val_o,
        output drop_o,
        output busy_o
    );
endinterface

// File: rtl/deserializer.sv
// Collects MSB-first serial bursts into parallel words. Bursts of 3..DATA_W-1 bits
// are emitted left-aligned with their bit count; bursts of 1 or 2 bits are dropped.
module deserializer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    deserializer_if.slave  bus
);
    // Count needs one extra bit so that DATA_W itself is representable
    localparam int unsigned CntW = MOD_W + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'b01,
        StReceive = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              val_q, val_d;
    logic              drop_q, drop_d;
    logic              busy_q;

    logic [DATA_W-1:0] shift_ins;
    logic [CntW-1:0]   bit_idx;

    // Shift register with the incoming bit placed at DATA_W-1-count; lower bits are
    // already zero because the register is cleared when a burst starts.
    always_comb begin
        bit_idx   = CntW'(DATA_W - 1) - cnt_q;
        shift_ins = shift_q | ({{(DATA_W-1){1'b0}}, bus.ser_data_i} << bit_idx);
    end

    // Next-state and output decode
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.ser_data_val_i) begin
                    shift_d             = '0;
                    shift_d[DATA_W-1]   = bus.ser_data_i;
                    cnt_d               = CntW'(1);
                    state_d             = StReceive;
                end
            end
            StReceive: begin
                if (bus.ser_data_val_i) begin
                    shift_d = shift_ins;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        // Full word completes on this edge; mod 0 encodes DATA_W
                        data_d  = shift_ins;
                        mod_d   = '0;
                        val_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    if (cnt_q >= CntW'(3)) begin
                        data_d = shift_q;
                        mod_d  = cnt_q[MOD_W-1:0];
                        val_d  = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d == StReceive);
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
    assign bus.drop_o           = drop_q;
    assign bus.busy_o           = busy_q;
endmodule

// File: tb/tb_deserializer.sv
// Directed and random checks for the deserializer.
module tb_deserializer;
    logic clk_i = 1'b0;
    logic rst_n_i = 1'b0;

    deserializer_if #(.DATA_W(16), .MOD_W(4)) bus ();

    deserializer #(.DATA_W(16), .MOD_W(4)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int n_val   = 0;
    int n_drop  = 0;
    int n_both  = 0;

    // Pulse monitor
    always @(negedge clk_i) begin
        if (bus.deser_data_val_o) n_val++;
        if (bus.drop_o) n_drop++;
        if (bus.deser_data_val_o && bus.drop_o) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive len bits MSB-first, then one idle cycle, then settle
    task automatic send_burst(input int len, input logic [15:0] data);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_i);
            bus.ser_data_val_i = 1'b1;
            bus.ser_data_i     = data[15-i];
        end
        @(negedge clk_i);
        bus.ser_data_val_i = 1'b0;
        bus.ser_data_i     = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    typedef struct {
        int          len;
        logic [15:0] data;
        int          exp_val;
        int          exp_drop;
        logic [15:0] exp_data;
        logic [3:0]  exp_mod;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, d0;
        logic [15:0] full;
        logic [15:0] rdata;
        int          rlen;

        vecs[0] = '{5,  16'hD800, 1, 0, 16'hD800, 4'd5};
        vecs[1] = '{2,  16'hC000, 0, 1, 16'hD800, 4'd5};
        vecs[2] = '{1,  16'h8000, 0, 1, 16'hD800, 4'd5};
        vecs[3] = '{3,  16'h4000, 1, 0, 16'h4000, 4'd3};
        vecs[4] = '{15, 16'hFFFE, 1, 0, 16'hFFFE, 4'd15};
        vecs[5] = '{16, 16'h0001, 1, 0, 16'h0001, 4'd0};
        vecs[6] = '{2,  16'h4000, 0, 1, 16'h0001, 4'd0};
        vecs[7] = '{8,  16'h3C00, 1, 0, 16'h3C00, 4'd8};

        bus.ser_data_i     = 1'b0;
        bus.ser_data_val_i = 1'b0;
        #12;
        check("reset_data", bus.deser_data_o, 0);
        check("reset_mod", bus.deser_data_mod_o, 0);
        check("reset_ctrl", {bus.deser_data_val_o, bus.drop_o, bus.busy_o}, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Full 16-bit word: latency and busy profile
        begin
            logic [15:0] w;
            w = 16'hA5C3;
            v0 = n_val;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk_i);
                if (i > 0) begin
                    check($sformatf("a5c3_busy_%0d", i), bus.busy_o, 1);
                    check($sformatf("a5c3_noval_%0d", i), bus.deser_data_val_o, 0);
                end
                bus.ser_data_val_i = 1'b1;
                bus.ser_data_i     = w[15-i];
            end
            @(negedge clk_i);
            bus.ser_data_val_i = 1'b0;
            check("a5c3_val", bus.deser_data_val_o, 1);
            check("a5c3_busy_end", bus.busy_o, 0);
            check("a5c3_data", bus.deser_data_o, 32'hA5C3);
            check("a5c3_mod", bus.deser_data_mod_o, 0);
            repeat (2) @(negedge clk_i);
            check("a5c3_one_pulse", n_val - v0, 1);
        end

        // Table-driven bursts
        for (int k = 0; k < 8; k++) begin
            v0 = n_val;
            d0 = n_drop;
            send_burst(vecs[k].len, vecs[k].data);
            check($sformatf("vec%0d_val", k), n_val - v0, vecs[k].exp_val);
            check($sformatf("vec%0d_drop", k), n_drop - d0, vecs[k].exp_drop);
            check($sformatf("vec%0d_data", k), bus.deser_data_o, vecs[k].exp_data);
            check($sformatf("vec%0d_mod", k), bus.deser_data_mod_o, vecs[k].exp_mod);
            check($sformatf("vec%0d_busy", k), bus.busy_o, 0);
        end

        // Back-to-back: FFFF then 0001 with valid held 32 cycles
        begin
            logic [31:0] w2;
            w2 = 32'hFFFF_0001;
            v0 = n_val;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk_i);
                if (i > 0)
                    check($sformatf("b2b_val_%0d", i), bus.deser_data_val_o, (i == 16));
                if (i == 16) check("b2b_word0", bus.deser_data_o, 32'hFFFF);
                bus.ser_data_val_i = 1'b1;
                bus.ser_data_i     = w2[31-i];
            end
            @(negedge clk_i);
            bus.ser_data_val_i = 1'b0;
            check("b2b_val_end", bus.deser_data_val_o, 1);
            check("b2b_word1", bus.deser_data_o, 32'h0001);
            check("b2b_mod", bus.deser_data_mod_o, 0);
            repeat (2) @(negedge clk_i);
            check("b2b_pulses", n_val - v0, 2);
        end

        // Asynchronous reset after 7 bits of a burst
        v0 = n_val;
        d0 = n_drop;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            bus.ser_data_val_i = 1'b1;
            bus.ser_data_i     = 1'b1;
        end
        @(posedge clk_i);
        #2;
        check("prerst_busy", bus.busy_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("rst_data", bus.deser_data_o, 0);
        check("rst_ctrl", {bus.deser_data_val_o, bus.drop_o, bus.busy_o, 4'(bus.deser_data_mod_o)},
              0);
        bus.ser_data_val_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        check("rst_no_pulse", (n_val - v0) + (n_drop - d0), 0);
        v0 = n_val;
        send_burst(16, 16'h1234);
        check("postrst_val", n_val - v0, 1);
        check("postrst_data", bus.deser_data_o, 32'h1234);
        check("postrst_mod", bus.deser_data_mod_o, 0);

        // Random widths 3..16
        full = 16'hFFFF;
        for (int k = 0; k < 20; k++) begin
            rlen  = int'($urandom_range(3, 16));
            rdata = 16'($urandom) & ~(full >> rlen);
            v0 = n_val;
            send_burst(rlen, rdata);
            check($sformatf("rnd%0d_val", k), n_val - v0, 1);
            check($sformatf("rnd%0d_data", k), bus.deser_data_o, rdata);
            check($sformatf("rnd%0d_mod", k), bus.deser_data_mod_o, rlen % 16);
        end

        check("never_both", n_both, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
